// File: rtl/signal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signal_pkg
// Description : Lamp colour encodings, controller state enum and a helper
//               that sizes the phase timer from the timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package signal_pkg;

    localparam logic [1:0] C_RED    = 2'b00;
    localparam logic [1:0] C_YELLOW = 2'b01;
    localparam logic [1:0] C_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        HG  = 3'd0,   // highway green, country red
        HY  = 3'd1,   // highway yellow, country red
        AR1 = 3'd2,   // all red before country green
        CG  = 3'd3,   // highway red, country green
        CY  = 3'd4,   // highway red, country yellow
        AR2 = 3'd5    // all red before highway green
    } state_t;

    // Largest of the four phase durations; the timer must hold its value.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timed_signal_controller_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Saturating up-counter that restarts from zero on every phase
//               entry and flags when the elapsed count reaches a limit.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             at_limit
);

    logic [WIDTH-1:0] r_count;

    // Count cycles spent in the current phase; hold at all-ones so it never wraps.
    always_ff @(posedge clk) begin
        if (clear || restart) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count equals (cycles elapsed - 1), so the limit is programmed as duration - 1.
    assign at_limit = (r_count >= limit);

endmodule
`default_nettype wire

// File: rtl/timed_signal_controller.sv
`default_nettype none
// ============================================================================
// Module      : timed_signal_controller
// Description : Highway / country-road intersection controller. Highway
//               holds green until country demand appears after a minimum
//               green; country green ends on demand loss or a maximum time.
// Revision    : 1.0 - initial release
// ============================================================================
module timed_signal_controller
    import signal_pkg::*;
#(
    parameter int Y2R_DLY         = 2,
    parameter int R2G_DLY         = 2,
    parameter int MIN_HWY_GREEN   = 4,
    parameter int MAX_CNTRY_GREEN = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase,
    output logic       cntry_timeout
);

    localparam int C_TW = $clog2(max4(Y2R_DLY, R2G_DLY, MIN_HWY_GREEN, MAX_CNTRY_GREEN) + 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [C_TW-1:0]   w_limit;
    logic              w_at_limit;
    logic              w_restart;
    logic              r_timeout;

    assign w_restart = (w_next_state != r_state);

    phase_timer #(
        .WIDTH (C_TW)
    ) u_phase_timer (
        .clk      (clk),
        .clear    (clear),
        .restart  (w_restart),
        .enable   (1'b1),
        .limit    (w_limit),
        .at_limit (w_at_limit)
    );

    // State register; clear overrides every transition and returns to highway green.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= HG;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Timeout pulse occupies the first country-yellow cycle after a max-time exit.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == CG) && x && w_at_limit;
        end
    end

    // Next-state and timer limit selection; unused codes behave as highway green.
    always_comb begin
        w_next_state = r_state;
        w_limit      = C_TW'(MIN_HWY_GREEN - 1);
        case (r_state)
            HG: begin
                w_limit = C_TW'(MIN_HWY_GREEN - 1);
                if (x && w_at_limit) w_next_state = HY;
            end
            HY: begin
                w_limit = C_TW'(Y2R_DLY - 1);
                if (w_at_limit) w_next_state = AR1;
            end
            AR1: begin
                w_limit = C_TW'(R2G_DLY - 1);
                if (w_at_limit) w_next_state = CG;
            end
            CG: begin
                w_limit = C_TW'(MAX_CNTRY_GREEN - 1);
                if (!x || w_at_limit) w_next_state = CY;
            end
            CY: begin
                w_limit = C_TW'(Y2R_DLY - 1);
                if (w_at_limit) w_next_state = AR2;
            end
            AR2: begin
                w_limit = C_TW'(R2G_DLY - 1);
                if (w_at_limit) w_next_state = HG;
            end
            default: begin
                w_limit = C_TW'(MIN_HWY_GREEN - 1);
                w_next_state = (x && w_at_limit) ? HY : HG;
            end
        endcase
    end

    // Moore decode of lamps and phase code from the state register.
    always_comb begin
        hwy   = C_GREEN;
        cntry = C_RED;
        phase = 3'd0;
        case (r_state)
            HY:  begin hwy = C_YELLOW; phase = r_state; end
            AR1: begin hwy = C_RED;    phase = r_state; end
            CG:  begin hwy = C_RED;    cntry = C_GREEN;  phase = r_state; end
            CY:  begin hwy = C_RED;    cntry = C_YELLOW; phase = r_state; end
            AR2: begin hwy = C_RED;    phase = r_state; end
            default: begin
                hwy   = C_GREEN;
                cntry = C_RED;
                phase = 3'd0;
            end
        endcase
    end

    assign cntry_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_timed_signal_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timed_signal_controller
// Description : Scoreboard bench for timed_signal_controller with a
//               duration-counting reference model and randomised demand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timed_signal_controller;

    localparam int Y2R = 2;
    localparam int R2G = 2;
    localparam int MIN = 4;
    localparam int MAX = 8;

    typedef struct packed {
        logic [1:0] hwy;
        logic [1:0] cntry;
        logic [2:0] phase;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       x = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] phase;
    logic       cntry_timeout;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: phase name (0..5) and how many cycles it has lasted so far.
    int   m_ph     = 0;
    int   m_lasted = 1;
    logic m_to     = 1'b0;

    timed_signal_controller #(
        .Y2R_DLY         (Y2R),
        .R2G_DLY         (R2G),
        .MIN_HWY_GREEN   (MIN),
        .MAX_CNTRY_GREEN (MAX)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .x             (x),
        .hwy           (hwy),
        .cntry         (cntry),
        .phase         (phase),
        .cntry_timeout (cntry_timeout)
    );

    always #5 clk = ~clk;

    // Advance the model across one rising edge given the inputs seen at that edge.
    task automatic model_step(input logic xin, input logic clr);
        int nxt;
        if (clr) begin
            m_ph = 0; m_lasted = 1; m_to = 1'b0;
        end else begin
            nxt  = m_ph;
            m_to = 1'b0;
            case (m_ph)
                0: if (xin && m_lasted >= MIN) nxt = 1;
                1: if (m_lasted == Y2R) nxt = 2;
                2: if (m_lasted == R2G) nxt = 3;
                3: begin
                    if (!xin) nxt = 4;
                    else if (m_lasted == MAX) begin nxt = 4; m_to = 1'b1; end
                end
                4: if (m_lasted == Y2R) nxt = 5;
                default: if (m_lasted == R2G) nxt = 0;
            endcase
            if (nxt != m_ph) begin
                m_ph = nxt; m_lasted = 1;
            end else if (m_lasted < 1000) begin
                m_lasted++;
            end
        end
    endtask

    function automatic exp_t expect_of(input int ph, input logic to);
        exp_t e;
        e.phase = 3'(ph);
        e.to    = to;
        case (ph)
            0: begin e.hwy = 2'b10; e.cntry = 2'b00; end
            1: begin e.hwy = 2'b01; e.cntry = 2'b00; end
            2: begin e.hwy = 2'b00; e.cntry = 2'b00; end
            3: begin e.hwy = 2'b00; e.cntry = 2'b10; end
            4: begin e.hwy = 2'b00; e.cntry = 2'b01; end
            default: begin e.hwy = 2'b00; e.cntry = 2'b00; end
        endcase
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and record the expected result.
    task automatic drive(input logic xin, input logic clr);
        @(negedge clk);
        x     = xin;
        clear = clr;
        model_step(xin, clr);
        exp_q.push_back(expect_of(m_ph, m_to));
    endtask

    // Monitor: after each rising edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (hwy !== e.hwy) begin
                    errors++;
                    $display("FAIL hwy cycle %0d: got %b expected %b", cyc, hwy, e.hwy);
                end
                checks++;
                if (cntry !== e.cntry) begin
                    errors++;
                    $display("FAIL cntry cycle %0d: got %b expected %b", cyc, cntry, e.cntry);
                end
                checks++;
                if (phase !== e.phase) begin
                    errors++;
                    $display("FAIL phase cycle %0d: got %0d expected %0d", cyc, phase, e.phase);
                end
                checks++;
                if (cntry_timeout !== e.to) begin
                    errors++;
                    $display("FAIL cntry_timeout cycle %0d: got %b expected %b", cyc, cntry_timeout, e.to);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then randomised demand bursts with rare clears.
    initial begin
        int run;
        logic xv;
        drive(1'b0, 1'b1);
        repeat (20) drive(1'b0, 1'b0);            // idle highway green
        repeat (40) drive(1'b1, 1'b0);            // full cycle incl. max-green timeout
        repeat (10) drive(1'b1, 1'b0);
        repeat (3)  drive(1'b1, 1'b0);
        repeat (6)  drive(1'b0, 1'b0);
        drive(1'b1, 1'b0); drive(1'b0, 1'b0);     // short pulse in early highway green
        repeat (6)  drive(1'b0, 1'b0);
        repeat (14) drive(1'b1, 1'b0);            // reach country green
        drive(1'b1, 1'b1);                        // abort mid-phase
        repeat (8)  drive(1'b1, 1'b0);
        for (int i = 0; i < 150; i++) begin
            run = $urandom_range(1, 12);
            xv  = 1'($urandom_range(0, 1));
            for (int j = 0; j < run; j++) begin
                drive(xv, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
            end
        end
        drive(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timed_signal_controller.md
TIMED_SIGNAL_CONTROLLER -- requirements
Module: timed_signal_controller

Interface
REQ-001 Parameter Y2R_DLY, default 2, cycles spent in each yellow phase (>=1).
REQ-002 Parameter R2G_DLY, default 2, cycles spent in each all-red clearance phase (>=1).
REQ-003 Parameter MIN_HWY_GREEN, default 4, minimum cycles of highway green before yielding (>=1).
REQ-004 Parameter MAX_CNTRY_GREEN, default 8, maximum cycles of country green while demand persists (>=1).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 clear  input  1  reset, synchronous, active-high.
REQ-007 x  input  1  country-road vehicle sensor; 1 = demand present.
REQ-008 hwy  output  2  highway lamp: red=2'b00, yellow=2'b01, green=2'b10.
REQ-009 cntry  output  2  country lamp, same encoding.
REQ-010 phase  output  3  current state encoding, for observation.
REQ-011 cntry_timeout  output  1  one-cycle pulse when country green ended by MAX_CNTRY_GREEN.

Function
REQ-012 States and encodings: HG=0 (hwy green/cntry red), HY=1 (yellow/red), AR1=2 (red/red), CG=3 (red/green), CY=4 (red/yellow), AR2=5 (red/red); codes 6-7 unreachable and treated as HG.
REQ-013 hwy, cntry and phase are Moore decodes of the state register only; they change in the cycle the state changes.
REQ-014 A phase timer resets to 0 on every state entry and increments once per cycle in that state.
REQ-015 HG -> HY on the first edge where x==1 and HG has lasted >= MIN_HWY_GREEN cycles; the timer saturates in HG, so HG may last indefinitely.
REQ-016 x is not latched: demand that drops before the minimum-green expiry is lost.
REQ-017 HY -> AR1 after exactly Y2R_DLY cycles; x ignored.
REQ-018 AR1 -> CG after exactly R2G_DLY cycles; x ignored.
REQ-019 CG -> CY on the first edge where x==0, or where CG has lasted MAX_CNTRY_GREEN cycles, whichever comes first.
REQ-020 CY -> AR2 after exactly Y2R_DLY cycles; AR2 -> HG after exactly R2G_DLY cycles; x ignored in both.
REQ-021 cntry_timeout is registered: high for exactly the first CY cycle when CG exited on the max-timer with x==1, otherwise 0.
REQ-022 x==0 and the timer at the limit on the same edge counts as x-exit: no timeout pulse.
REQ-023 The timer width is derived from the largest parameter and never wraps.

Reset
REQ-024 clear sampled high at an edge forces the next state to HG with timer=0 and cntry_timeout=0 (hwy=green, cntry=red, phase=0), overriding all transitions.
REQ-025 clear mid-phase (any state) aborts the phase with no yellow or clearance sequence; minimum green restarts from 0.

Structure
REQ-026 Package signal_pkg holds the colour encodings (red, yellow, green) and the state enum/constants.
REQ-027 One sub-module, phase_timer: parameterised-width counter with a clear-on-entry input, a saturating enable and a compare output; the FSM instantiates it once.

Verification (defaults; cycle 0 = first edge after clear released)
REQ-028 clear for 1 cycle, x=0 for 20 cycles -> hwy=10, cntry=00, phase=0 throughout, cntry_timeout=0.
REQ-029 x=1 from cycle 0 -> HG cycles 0-3, HY 4-5, AR1 6-7, CG from cycle 8 (hwy=00, cntry=10).
REQ-030 x held at 1 -> CG lasts exactly 8 cycles, cntry_timeout=1 only in the first CY cycle, then CY 2 cycles, AR2 2 cycles, HG lasts exactly 4 cycles before HY.
REQ-031 x dropped after 3 CG cycles -> CY on the next cycle, cntry_timeout stays 0.
REQ-032 1-cycle x pulse in HG cycle 1 and x pulse during HY/AR1 -> HG continues / phase durations unchanged.
REQ-033 clear asserted in the second CG cycle -> next cycle hwy=10, cntry=00, phase=0; then x=1 -> HY no earlier than 4 cycles later.
